// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD up/down counter with scanned 7-segment display.
// Segment codes are active-high in gfedcba order.
package bcd_disp_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Width of a counter holding 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down counter. Steps when i_step_in is high and passes
// a carry/borrow to the next digit through o_step_out.
module bcd_digit_cell
   import bcd_disp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_up,
   input  logic       i_step_in,
   input  logic       i_clr,
   output logic [3:0] o_digit,
   output logic [3:0] o_digit_nxt,
   output logic       o_step_out
);

   logic [3:0] r_digit;
   logic [3:0] w_digit_nxt;
   logic       w_at_max;
   logic       w_at_min;

   // Non-BCD codes behave as 9 going up and as 0 going down, so they wrap out.
   assign w_at_max = (r_digit >= BCD_MAX);
   assign w_at_min = (r_digit == 4'd0) || (r_digit > BCD_MAX);

   always_comb begin
      // NOTE: default first so every path assigns w_digit_nxt and no latch is inferred.
      w_digit_nxt = r_digit;
      if (i_clr) begin
         w_digit_nxt = 4'd0;
      end else if (i_step_in) begin
         if (i_up) w_digit_nxt = w_at_max ? 4'd0 : r_digit + 4'd1;
         else      w_digit_nxt = w_at_min ? BCD_MAX : r_digit - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_digit <= 4'd0;
      else       r_digit <= w_digit_nxt;
   end

   assign o_digit     = r_digit;
   assign o_digit_nxt = w_digit_nxt;
   assign o_step_out  = i_step_in && (i_up ? w_at_max : w_at_min);

endmodule

// File: rtl/bcd_updown_scan_display.sv
// N-digit BCD up/down counter with a display-hold register and a time-multiplexed
// 7-segment scan driver; all timing comes from enable strobes on clk.
module bcd_updown_scan_display
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 5000000,
   parameter int SCAN_DIV = 125000,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   input  logic                  LE,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic [7:0]            out_bcd,
   output logic [DIGITS-1:0]     out_decod
);

   localparam int TICK_W = cnt_width(TICK_DIV);
   localparam int SCAN_W = cnt_width(SCAN_DIV);
   localparam int IDX_W  = cnt_width(DIGITS);

   logic [TICK_W-1:0]   r_tick_cnt;
   logic                w_tick;
   logic [DIGITS:0]     w_step;
   logic [4*DIGITS-1:0] w_count_nxt;
   logic                r_tc;
   logic [4*DIGITS-1:0] r_disp;
   logic [SCAN_W-1:0]   r_scan_cnt;
   logic                w_scan_wrap;
   logic [IDX_W-1:0]    r_idx;
   logic [DIGITS:0]     w_lz;
   logic [3:0]          w_sel_digit;
   logic                w_sel_blank;
   logic [DIGITS-1:0]   r_out_decod;
   logic [7:0]          r_out_bcd;

   assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)       r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   assign w_step[0] = w_tick && en;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
         .clk         (clk),
         .reset       (reset),
         .i_up        (up),
         .i_step_in   (w_step[g]),
         .i_clr       (clr),
         .o_digit     (count[4*g +: 4]),
         .o_digit_nxt (w_count_nxt[4*g +: 4]),
         .o_step_out  (w_step[g+1])
      );
   end

   // A step leaving the top digit means the whole counter wrapped.
   always_ff @(posedge clk) begin
      if (reset) r_tc <= 1'b0;
      else       r_tc <= w_step[DIGITS] && !clr;
   end

   assign tc = r_tc;

   always_ff @(posedge clk) begin
      if (reset)   r_disp <= '0;
      else if (LE) r_disp <= w_count_nxt;
   end

   assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else if (w_scan_wrap) begin
         r_scan_cnt <= '0;
         r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
      end
   end

   // w_lz[k] is set when display digits k..DIGITS-1 are all zero.
   assign w_lz[DIGITS] = 1'b1;
   for (genvar g = 0; g < DIGITS; g++) begin : g_lz
      assign w_lz[g] = w_lz[g+1] && (r_disp[4*g +: 4] == 4'd0);
   end

   always_comb begin
      w_sel_digit = 4'd0;
      w_sel_blank = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_sel_digit = r_disp[4*k +: 4];
            w_sel_blank = (BLANK_LZ != 0) && (k != 0) && w_lz[k];
         end
      end
   end

   // Select and segments share one register stage so they can never skew.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_decod <= DIGITS'(1);
         r_out_bcd   <= {1'b0, SEG_0};
      end else begin
         r_out_decod <= DIGITS'(1) << r_idx;
         r_out_bcd   <= {1'b0, w_sel_blank ? SEG_BLANK : bcd_to_seg(w_sel_digit)};
      end
   end

   assign out_decod = r_out_decod;
   assign out_bcd   = r_out_bcd;

endmodule
